cardinal_link_port: RTL and testbench

// - Router-side endpoint of the NIC network link: the peer of cardinal_nic's net_* pins.
// - Ingress: accepts packets the NIC drives (net_so/net_ro/net_do) and forwards them to the router crossbar.
// - Egress: accepts packets from the crossbar and drives them to the NIC (net_si/net_ri/net_di).
// - Two virtual channels (even = 0, odd = 1); a packet's VC is data bit [0]; one 1-deep buffer per VC per direction.

---
 rtl/cardinal_link_port.sv | 156 +++++++++++++++
 tb/tb_cardinal_link_port.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_link_port.sv
// cardinal_link_port: router-side endpoint of the NIC network link.
// Ingress path takes NIC packets (net_so/net_ro/net_do) into the crossbar (xbar_tx_*).
// Egress path takes crossbar packets (xbar_rx_*) out to the NIC (net_si/net_ri/net_di).
// Two virtual channels, one 1-deep buffer per VC per direction. A packet's VC is bit [0],
// and the data vectors are numbered MSB-first [0:DW-1], so the VC bit is the MSB.
// Link VC = polarity and internal VC = ~polarity. The link side only ever touches the
// link VC and the crossbar side only the internal VC, so one buffer is never filled and
// drained in the same cycle.
// Optional statistics counters are enabled by defining LINK_STATS_EN. Without it, cnt_in
// and cnt_out are tied to zero.
module cardinal_link_port #(
  parameter int DW    = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  input  logic             net_so,
  output logic             net_ro,
  input  logic [0:DW-1]    net_do,
  output logic             net_si,
  input  logic             net_ri,
  output logic [0:DW-1]    net_di,
  output logic             xbar_tx_valid,
  input  logic             xbar_tx_ready,
  output logic [0:DW-1]    xbar_tx_data,
  input  logic             xbar_rx_valid,
  output logic             xbar_rx_ready,
  input  logic [0:DW-1]    xbar_rx_data,
  output logic             vc_err,
  output logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] cnt_out
);

  // Per-VC buffer state, index 0 = even VC, index 1 = odd VC.
  logic [1:0]    in_full;
  logic [1:0]    out_full;
  logic [0:DW-1] in_buf  [2];
  logic [0:DW-1] out_buf [2];
  logic          err_q;

  // VC currently owned by the NIC link and VC currently owned by the crossbar.
  logic link_vc;
  logic int_vc;
  assign link_vc = polarity;
  assign int_vc  = ~polarity;

  // Handshake decode for this cycle.
  logic in_take;
  logic in_push;
  logic in_drop;
  logic in_pop;
  logic out_take;
  logic out_push;
  logic out_drop;
  logic out_pop;

  // Drive the port outputs from the buffer selected by the current polarity.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    net_ro        = 1'b0;
    xbar_rx_ready = 1'b0;
    xbar_tx_valid = 1'b0;
    xbar_tx_data  = '0;
    net_si        = 1'b0;
    net_di        = '0;

    net_ro        = ~in_full[link_vc];
    xbar_tx_valid = in_full[int_vc];
    xbar_tx_data  = in_buf[int_vc];
    xbar_rx_ready = ~out_full[int_vc];
    net_si        = out_full[link_vc];
    if (out_full[link_vc]) begin
      net_di = out_buf[link_vc];
    end
  end

  // Classify each accepted packet as stored (right VC) or dropped (wrong VC).
  always_comb begin
    // NOTE: combinational logic uses blocking '=', so later lines see the values computed above them in the same pass.
    in_take  = net_so & net_ro;
    in_push  = in_take & (net_do[0] == link_vc);
    in_drop  = in_take & (net_do[0] != link_vc);
    in_pop   = xbar_tx_valid & xbar_tx_ready;
    out_take = xbar_rx_valid & xbar_rx_ready;
    out_push = out_take & (xbar_rx_data[0] == int_vc);
    out_drop = out_take & (xbar_rx_data[0] != int_vc);
    out_pop  = net_si & net_ri;
  end

  // Buffer fill/drain. Fill and drain always target different VCs in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_full    <= '0;
      out_full   <= '0;
      // NOTE: the data buffers are reset too, because net_di and xbar_tx_data must read zero straight after reset.
      in_buf[0]  <= '0;
      in_buf[1]  <= '0;
      out_buf[0] <= '0;
      out_buf[1] <= '0;
    end else begin
      if (in_push) begin
        in_full[link_vc] <= 1'b1;
        in_buf[link_vc]  <= net_do;
      end
      if (in_pop) begin
        in_full[int_vc] <= 1'b0;
      end
      if (out_push) begin
        out_full[int_vc] <= 1'b1;
        out_buf[int_vc]  <= xbar_rx_data;
      end
      if (out_pop) begin
        out_full[link_vc] <= 1'b0;
      end
    end
  end

  // Sticky VC error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (in_drop || out_drop) begin
      err_q <= 1'b1;
    end
  end

  assign vc_err = err_q;

`ifdef LINK_STATS_EN
  logic [CNT_W-1:0] cnt_in_q;
  logic [CNT_W-1:0] cnt_out_q;

  // Saturating packet counters. Dropped wrong-VC packets are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
    end else begin
      if (in_push && (cnt_in_q != '1)) begin
        cnt_in_q <= cnt_in_q + CNT_W'(1);
      end
      if (out_pop && (cnt_out_q != '1)) begin
        cnt_out_q <= cnt_out_q + CNT_W'(1);
      end
    end
  end

  assign cnt_in  = cnt_in_q;
  assign cnt_out = cnt_out_q;
`else
  assign cnt_in  = '0;
  assign cnt_out = '0;
`endif

endmodule

// File: tb/tb_cardinal_link_port.sv
// Self-checking bench for cardinal_link_port.
// A directed vector table carries its own expected handshake flags. A per-VC scoreboard
// (queues per direction) predicts every output cycle by cycle. Hand-written sequences cover
// reset mid-transfer and the statistics counters. Counter expectations follow LINK_STATS_EN.
module tb_cardinal_link_port;
  localparam int DW    = 64;
  localparam int CNT_W = 16;
`ifdef LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             polarity;
  logic             net_so;
  logic             net_ro;
  logic [0:DW-1]    net_do;
  logic             net_si;
  logic             net_ri;
  logic [0:DW-1]    net_di;
  logic             xbar_tx_valid;
  logic             xbar_tx_ready;
  logic [0:DW-1]    xbar_tx_data;
  logic             xbar_rx_valid;
  logic             xbar_rx_ready;
  logic [0:DW-1]    xbar_rx_data;
  logic             vc_err;
  logic [CNT_W-1:0] cnt_in;
  logic [CNT_W-1:0] cnt_out;

  cardinal_link_port #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .polarity      (polarity),
    .net_so        (net_so),
    .net_ro        (net_ro),
    .net_do        (net_do),
    .net_si        (net_si),
    .net_ri        (net_ri),
    .net_di        (net_di),
    .xbar_tx_valid (xbar_tx_valid),
    .xbar_tx_ready (xbar_tx_ready),
    .xbar_tx_data  (xbar_tx_data),
    .xbar_rx_valid (xbar_rx_valid),
    .xbar_rx_ready (xbar_rx_ready),
    .xbar_rx_data  (xbar_rx_data),
    .vc_err        (vc_err),
    .cnt_in        (cnt_in),
    .cnt_out       (cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          pol;
    logic          so;
    logic [0:DW-1] dout;
    logic          ri;
    logic          txr;
    logic          rxv;
    logic [0:DW-1] rxd;
    logic          e_ro;
    logic          e_si;
    logic          e_txv;
    logic          e_rxr;
    logic          e_err;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: each queue holds at most one packet (the 1-deep buffer of that VC).
  logic [0:DW-1]    ing_q0[$];
  logic [0:DW-1]    ing_q1[$];
  logic [0:DW-1]    egr_q0[$];
  logic [0:DW-1]    egr_q1[$];
  logic             m_err;
  logic [CNT_W-1:0] m_cnt_in;
  logic [CNT_W-1:0] m_cnt_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 64'(act), 64'(exp));
  endtask

  function automatic int q_size(input bit egr, input bit vc);
    if (!egr) return vc ? ing_q1.size() : ing_q0.size();
    return vc ? egr_q1.size() : egr_q0.size();
  endfunction

  function automatic logic [0:DW-1] q_front(input bit egr, input bit vc);
    if (!egr) return vc ? ing_q1[0] : ing_q0[0];
    return vc ? egr_q1[0] : egr_q0[0];
  endfunction

  task automatic q_push(input bit egr, input bit vc, input logic [0:DW-1] d);
    if (!egr) begin
      if (vc) ing_q1.push_back(d); else ing_q0.push_back(d);
    end else begin
      if (vc) egr_q1.push_back(d); else egr_q0.push_back(d);
    end
  endtask

  task automatic q_pop(input bit egr, input bit vc);
    if (!egr) begin
      if (vc) void'(ing_q1.pop_front()); else void'(ing_q0.pop_front());
    end else begin
      if (vc) void'(egr_q1.pop_front()); else void'(egr_q0.pop_front());
    end
  endtask

  task automatic model_clear();
    ing_q0.delete();
    ing_q1.delete();
    egr_q0.delete();
    egr_q1.delete();
    m_err     = 1'b0;
    m_cnt_in  = '0;
    m_cnt_out = '0;
  endtask

  function automatic vec_t mkv(input logic pol, input logic so, input logic [0:DW-1] dout,
                               input logic ri, input logic txr, input logic rxv,
                               input logic [0:DW-1] rxd, input logic ro, input logic si,
                               input logic txv, input logic rxr, input logic err);
    vec_t v;
    v.rst = 1'b0; v.pol = pol; v.so = so; v.dout = dout; v.ri = ri; v.txr = txr;
    v.rxv = rxv; v.rxd = rxd; v.e_ro = ro; v.e_si = si; v.e_txv = txv; v.e_rxr = rxr;
    v.e_err = err;
    return v;
  endfunction

  // One clock: drive at negedge, compare just after, advance the model, then take the posedge.
  task automatic run(input vec_t x, input bit use_exp, input string tag);
    bit            l;
    bit            i;
    logic          exp_ro;
    logic          exp_si;
    logic          exp_txv;
    logic          exp_rxr;
    logic [0:DW-1] exp_di;
    @(negedge clk);
    reset         = x.rst;
    polarity      = x.pol;
    net_so        = x.so;
    net_do        = x.dout;
    net_ri        = x.ri;
    xbar_tx_ready = x.txr;
    xbar_rx_valid = x.rxv;
    xbar_rx_data  = x.rxd;
    #1;
    l       = x.pol;
    i       = ~x.pol;
    exp_ro  = (q_size(1'b0, l) == 0);
    exp_txv = (q_size(1'b0, i) != 0);
    exp_si  = (q_size(1'b1, l) != 0);
    exp_rxr = (q_size(1'b1, i) == 0);
    exp_di  = exp_si ? q_front(1'b1, l) : '0;
    check_bit({tag, ".net_ro"}, net_ro, exp_ro);
    check_bit({tag, ".xbar_tx_valid"}, xbar_tx_valid, exp_txv);
    check_bit({tag, ".net_si"}, net_si, exp_si);
    check_bit({tag, ".xbar_rx_ready"}, xbar_rx_ready, exp_rxr);
    check_bit({tag, ".vc_err"}, vc_err, m_err);
    check({tag, ".net_di"}, net_di, exp_di);
    if (exp_txv) check({tag, ".xbar_tx_data"}, xbar_tx_data, q_front(1'b0, i));
    check({tag, ".cnt_in"}, 64'(cnt_in), STATS ? 64'(m_cnt_in) : 64'd0);
    check({tag, ".cnt_out"}, 64'(cnt_out), STATS ? 64'(m_cnt_out) : 64'd0);
    if (use_exp) begin
      check_bit({tag, ".tbl_ro"}, net_ro, x.e_ro);
      check_bit({tag, ".tbl_si"}, net_si, x.e_si);
      check_bit({tag, ".tbl_txv"}, xbar_tx_valid, x.e_txv);
      check_bit({tag, ".tbl_rxr"}, xbar_rx_ready, x.e_rxr);
      check_bit({tag, ".tbl_err"}, vc_err, x.e_err);
    end
    if (x.rst) begin
      model_clear();
    end else begin
      if (x.so && exp_ro) begin
        if (x.dout[0] == l) begin
          q_push(1'b0, l, x.dout);
          if (m_cnt_in != '1) m_cnt_in = m_cnt_in + CNT_W'(1);
        end else begin
          m_err = 1'b1;
        end
      end
      if (exp_txv && x.txr) q_pop(1'b0, i);
      if (x.rxv && exp_rxr) begin
        if (x.rxd[0] == i) q_push(1'b1, i, x.rxd);
        else m_err = 1'b1;
      end
      if (exp_si && x.ri) begin
        q_pop(1'b1, l);
        if (m_cnt_out != '1) m_cnt_out = m_cnt_out + CNT_W'(1);
      end
    end
    @(posedge clk);
  endtask

  localparam logic [0:DW-1] PKT_A = 64'h8A0C000000000001; // VC 1
  localparam logic [0:DW-1] PKT_B = 64'hC000000000000003; // VC 1
  localparam logic [0:DW-1] PKT_E = 64'h0000000000000002; // VC 0
  localparam logic [0:DW-1] PKT_X = 64'h0123456789ABCDEF; // VC 0
  localparam logic [0:DW-1] PKT_D = 64'hF0000000000000AA; // VC 1
  localparam logic [0:DW-1] Z     = 64'h0;

  vec_t tbl [18];
  vec_t v;

  initial begin
    // Columns: pol so dout ri txr rxv rxd | ro si txv rxr err
    tbl[0]  = mkv(1, 1, PKT_A, 0, 1, 0, Z,     1, 0, 0, 1, 0);
    tbl[1]  = mkv(0, 0, Z,     0, 1, 0, Z,     1, 0, 1, 1, 0);
    tbl[2]  = mkv(1, 0, Z,     0, 1, 0, Z,     1, 0, 0, 1, 0);
    tbl[3]  = mkv(1, 1, PKT_A, 0, 0, 0, Z,     1, 0, 0, 1, 0);
    tbl[4]  = mkv(0, 1, PKT_E, 0, 0, 0, Z,     1, 0, 1, 1, 0);
    tbl[5]  = mkv(1, 1, PKT_B, 0, 0, 0, Z,     0, 0, 1, 1, 0);
    tbl[6]  = mkv(0, 0, Z,     0, 1, 0, Z,     0, 0, 1, 1, 0);
    tbl[7]  = mkv(1, 0, Z,     0, 1, 0, Z,     1, 0, 1, 1, 0);
    tbl[8]  = mkv(0, 0, Z,     0, 1, 0, Z,     1, 0, 0, 1, 0);
    tbl[9]  = mkv(1, 0, Z,     0, 1, 1, PKT_X, 1, 0, 0, 1, 0);
    tbl[10] = mkv(0, 0, Z,     0, 1, 0, Z,     1, 1, 0, 1, 0);
    tbl[11] = mkv(1, 0, Z,     0, 1, 0, Z,     1, 0, 0, 0, 0);
    tbl[12] = mkv(0, 0, Z,     1, 1, 0, Z,     1, 1, 0, 1, 0);
    tbl[13] = mkv(1, 0, Z,     0, 1, 0, Z,     1, 0, 0, 1, 0);
    tbl[14] = mkv(0, 1, PKT_A, 0, 1, 0, Z,     1, 0, 0, 1, 0);
    tbl[15] = mkv(1, 0, Z,     0, 1, 0, Z,     1, 0, 0, 1, 1);
    tbl[16] = mkv(0, 0, Z,     0, 1, 1, PKT_X, 1, 0, 0, 1, 1);
    tbl[17] = mkv(1, 0, Z,     0, 1, 0, Z,     1, 0, 0, 1, 1);

    reset = 1'b1; polarity = 1'b0; net_so = 1'b0; net_do = '0; net_ri = 1'b0;
    xbar_tx_ready = 1'b0; xbar_rx_valid = 1'b0; xbar_rx_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_bit("rst.net_ro", net_ro, 1'b1);
    check_bit("rst.xbar_rx_ready", xbar_rx_ready, 1'b1);
    check_bit("rst.net_si", net_si, 1'b0);
    check_bit("rst.xbar_tx_valid", xbar_tx_valid, 1'b0);
    check_bit("rst.vc_err", vc_err, 1'b0);
    check("rst.net_di", net_di, 64'h0);
    check("rst.xbar_tx_data", xbar_tx_data, 64'h0);

    for (int k = 0; k < 18; k++) run(tbl[k], 1'b1, $sformatf("tbl%0d", k));

    // Reset mid-transfer with both directions holding packets on both VCs.
    v = mkv(0, 0, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0);
    v.rst = 1'b1;
    run(v, 1'b0, "mid.rst0");
    run(mkv(1, 1, PKT_A, 0, 0, 1, PKT_X, 0, 0, 0, 0, 0), 1'b0, "mid.fill1");
    run(mkv(0, 1, PKT_E, 0, 0, 1, PKT_D, 0, 0, 0, 0, 0), 1'b0, "mid.fill0");
    run(mkv(1, 0, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0), 1'b0, "mid.hold");
    check_bit("mid.full_ro", net_ro, 1'b0);
    check_bit("mid.full_rxr", xbar_rx_ready, 1'b0);
    v = mkv(0, 0, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0);
    v.rst = 1'b1;
    run(v, 1'b0, "mid.rst1");
    run(mkv(1, 0, Z, 0, 0, 0, Z, 1, 0, 0, 1, 0), 1'b1, "mid.after1");
    run(mkv(0, 0, Z, 0, 0, 0, Z, 1, 0, 0, 1, 0), 1'b1, "mid.after0");

    // Three clean transfers each way.
    for (int k = 0; k < 3; k++) begin
      logic [0:DW-1] din;
      logic [0:DW-1] dx;
      din = {$urandom, $urandom};
      din[0] = 1'b1;
      dx = {$urandom, $urandom};
      dx[0] = 1'b0;
      run(mkv(1, 1, din, 1, 1, 1, dx, 0, 0, 0, 0, 0), 1'b0, $sformatf("xfer%0d.a", k));
      run(mkv(0, 0, Z, 1, 1, 0, Z, 0, 0, 0, 0, 0), 1'b0, $sformatf("xfer%0d.b", k));
    end
    @(negedge clk);
    #1;
    check("stats.cnt_in", 64'(cnt_in), STATS ? 64'd3 : 64'd0);
    check("stats.cnt_out", 64'(cnt_out), STATS ? 64'd3 : 64'd0);

    // Random traffic against the scoreboard, with polarity toggling every cycle.
    for (int k = 0; k < 300; k++) begin
      vec_t r;
      r = mkv(k[0], 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
              0, 0, 0, 0, 0);
      if ($urandom_range(0, 7) != 0) r.dout[0] = k[0];
      if ($urandom_range(0, 7) != 0) r.rxd[0] = ~k[0];
      run(r, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
